fifo_uart_tx_reader: RTL

Read-side consumer of the clock-domain-crossing FIFO: pops bytes from the FIFO read port and serializes each as an asynchronous UART frame. A frame is a start bit, DATA_WIDTH data bits LSB first, an optional parity bit, and one stop bit. The block sits in the FIFO read clock domain and drives the system's serial TX line. It is the transmit end of the byte stream that the FIFO buffers.

---
 rtl/fifo_uart_tx_reader_pkg.sv | 29 ++
 rtl/fifo_uart_tx_reader_tx_bit_timer.sv | 37 +++
 rtl/fifo_uart_tx_reader.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_reader_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// Holds the frame state encoding and the parity-type constants.
package fifo_uart_tx_reader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic frame_parity(
    input logic [63:0] data,
    input int unsigned width,
    input logic        typ
  );
    logic p;
    p = typ;
    for (int i = 0; i < 64; i++) begin
      if (i < width) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_reader_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled.
// Ports: clk, rst, clr_i (restart at 0), en_i, bit_done_o (last cycle).
module tx_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic bit_done_o
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_done_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == LAST) cnt_d = '0;
      else               cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_uart_tx_reader.sv
// Pops bytes from the CDC FIFO read port and sends each as a UART frame.
// Ports: clk, rst, fifo_empty, fifo_rd_data, fifo_r_inc, tx_en, par_en,
//        par_typ, tx_out (serial line, idles high), busy.
module fifo_uart_tx_reader
  import fifo_uart_tx_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_r_inc,
  input  logic                  tx_en,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int IW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

  tx_state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [IW-1:0] idx_q, idx_d;
  logic par_q, par_d;
  logic pen_q, pen_d;
  logic tx_q, tx_d;
  logic busy_q, busy_d;
  logic rinc_q, rinc_d;

  logic bit_done;
  logic load;
  logic timer_en;

  // A new frame may start from IDLE or straight out of the
  // final STOP cycle, which gives gapless back-to-back frames.
  assign load = tx_en && !fifo_empty &&
                ((state_q == IDLE) ||
                 ((state_q == STOP) && bit_done));

  assign timer_en = (state_q != IDLE);

  tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (load),
    .en_i      (timer_en),
    .bit_done_o(bit_done)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    par_d   = par_q;
    pen_d   = pen_q;
    tx_d    = 1'b1;
    busy_d  = 1'b0;
    rinc_d  = 1'b0;

    unique case (state_q)
      IDLE: state_d = IDLE;
      START: begin
        if (bit_done) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = pen_q ? PARITY : STOP;
          end else begin
            idx_d   = idx_q + IW'(1);
            shreg_d = shreg_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
      STOP: begin
        if (bit_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Frame setup overrides the STOP->IDLE exit above.
    if (load) begin
      state_d = START;
      shreg_d = fifo_rd_data;
      idx_d   = '0;
      pen_d   = par_en;
      par_d   = frame_parity(64'(fifo_rd_data),
                             DATA_WIDTH, par_typ);
      rinc_d  = 1'b1;
    end

    // Line level is decoded from the next state so the
    // output register changes exactly on bit boundaries.
    unique case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_q;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      pen_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      rinc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      pen_q   <= pen_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      rinc_q  <= rinc_d;
    end
  end

  assign tx_out     = tx_q;
  assign busy       = busy_q;
  assign fifo_r_inc = rinc_q;

endmodule
